// File: rtl/r2mdc_commutator_if.sv
// Sample-pair stream between radix-2 butterfly stages: inputs from Y0/Y1 and reordered outputs for the next stage.
interface r2mdc_commutator_if;
    logic               in_valid;
    logic signed [15:0] in_a_re;
    logic signed [15:0] in_a_im;
    logic signed [15:0] in_b_re;
    logic signed [15:0] in_b_im;
    logic               out_valid;
    logic signed [15:0] out_a_re;
    logic signed [15:0] out_a_im;
    logic signed [15:0] out_b_re;
    logic signed [15:0] out_b_im;

    modport master (
        output in_valid, in_a_re, in_a_im, in_b_re, in_b_im,
        input  out_valid, out_a_re, out_a_im, out_b_re, out_b_im
    );

    modport slave (
        input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im,
        output out_valid, out_a_re, out_a_im, out_b_re, out_b_im
    );
endinterface

// File: rtl/r2mdc_commutator.sv
// R2MDC delay-commutator: 1-cycle registered latency, stalls (holds all state) whenever in_valid is low.
// Optional COMMUTATOR_SCALE_EN halves every output component with round-half-up at no extra latency.
module r2mdc_commutator #(
    parameter int DELAY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    r2mdc_commutator_if.slave     io_bus
);
    localparam int CW = $clog2(2 * DELAY);

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } cplx_t;

    function automatic logic [15:0] f_scale(input logic [15:0] x);
`ifdef COMMUTATOR_SCALE_EN
        return 16'(($signed({x[15], x}) + 17'sd1) >>> 1);
`else
        return x;
`endif
    endfunction

    function automatic cplx_t f_scale_c(input cplx_t c);
        cplx_t res;
        res.re = f_scale(c.re);
        res.im = f_scale(c.im);
        return res;
    endfunction

    cplx_t         r_l [DELAY];
    cplx_t         r_u [DELAY];
    logic [CW-1:0] r_cnt;
    logic          r_primed;
    logic          r_out_vld;
    cplx_t         r_out_a;
    cplx_t         r_out_b;

    logic  w_accept;
    logic  w_sel;
    cplx_t w_in_a;
    cplx_t w_in_b;
    cplx_t w_l_out;
    cplx_t w_u_out;
    cplx_t w_sw_up;
    cplx_t w_sw_lo;

    assign w_accept = io_bus.in_valid & ~rst;
    assign w_in_a   = {io_bus.in_a_re, io_bus.in_a_im};
    assign w_in_b   = {io_bus.in_b_re, io_bus.in_b_im};
    assign w_l_out  = r_l[DELAY-1];
    assign w_u_out  = r_u[DELAY-1];
    // 2*DELAY is a power of two, so the counter MSB is (cnt div DELAY) mod 2.
    assign w_sel    = r_cnt[CW-1];

    always_comb begin
        w_sw_up = w_in_a;
        w_sw_lo = w_l_out;
        if (w_sel) begin
            w_sw_up = w_l_out;
            w_sw_lo = w_in_a;
        end
    end

    // Delay lines carry no reset: unprimed contents never reach a valid output.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_l[0] <= w_in_b;
            r_u[0] <= w_sw_up;
            for (int i = 1; i < DELAY; i++) begin
                r_l[i] <= r_l[i-1];
                r_u[i] <= r_u[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_a   <= '0;
            r_out_b   <= '0;
        end else begin
            r_out_vld <= io_bus.in_valid & r_primed;
            if (io_bus.in_valid) begin
                r_cnt   <= r_cnt + CW'(1);
                r_out_a <= f_scale_c(w_u_out);
                r_out_b <= f_scale_c(w_sw_lo);
                if (r_cnt == CW'(DELAY - 1)) begin
                    r_primed <= 1'b1;
                end
            end
        end
    end

    assign io_bus.out_valid = r_out_vld;
    assign io_bus.out_a_re  = r_out_a.re;
    assign io_bus.out_a_im  = r_out_a.im;
    assign io_bus.out_b_re  = r_out_b.re;
    assign io_bus.out_b_im  = r_out_b.im;
endmodule

// File: tb/tb_r2mdc_commutator.sv
// Bench for r2mdc_commutator at DELAY=2 and DELAY=1, with a stream-level reorder model and literal spot checks.
module tb_r2mdc_commutator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2;
    logic rst1;
    r2mdc_commutator_if bus2 ();
    r2mdc_commutator_if bus1 ();

    r2mdc_commutator #(.DELAY(2)) dut2 (.clk(clk), .rst(rst2), .io_bus(bus2));
    r2mdc_commutator #(.DELAY(1)) dut1 (.clk(clk), .rst(rst1), .io_bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [15:0] sc(input logic [15:0] x);
`ifdef COMMUTATOR_SCALE_EN
        int v;
        v = int'($signed(x));
        v = (v + 1) >>> 1;
        return v[15:0];
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] sc32(input logic [31:0] c);
        return {sc(c[31:16]), sc(c[15:0])};
    endfunction

    // Stream model: output for accepted sample n (since reset) with block size D.
    logic [31:0] ha [2][256];
    logic [31:0] hb [2][256];
    int          cnt_m [2];
    logic        ev [2];
    logic        known [2];
    logic        armed [2];
    logic [31:0] ea [2];
    logic [31:0] eb [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            ev[i] = 0; known[i] = 0; armed[i] = 0; cnt_m[i] = 0; ea[i] = 0; eb[i] = 0;
        end
    end

    task automatic step(input int i, input int d, input logic r, input logic v,
                        input logic [31:0] a, input logic [31:0] b);
        int n;
        if (r) begin
            armed[i] = 1; ev[i] = 0; known[i] = 1; ea[i] = 0; eb[i] = 0; cnt_m[i] = 0;
        end else if (!v) begin
            ev[i] = 0;
        end else begin
            n = cnt_m[i];
            ha[i][n % 256] = a;
            hb[i][n % 256] = b;
            if ((n % (2 * d)) >= d) begin
                ev[i] = 1; known[i] = 1;
                ea[i] = sc32(ha[i][(n - d) % 256]);
                eb[i] = sc32(a);
            end else if (n >= 2 * d) begin
                ev[i] = 1; known[i] = 1;
                ea[i] = sc32(hb[i][(n - 2 * d) % 256]);
                eb[i] = sc32(hb[i][(n - d) % 256]);
            end else begin
                ev[i] = 0; known[i] = 0;
            end
            cnt_m[i] = n + 1;
        end
    endtask

    always @(posedge clk) begin
        step(0, 2, rst2, bus2.in_valid, {bus2.in_a_re, bus2.in_a_im}, {bus2.in_b_re, bus2.in_b_im});
        step(1, 1, rst1, bus1.in_valid, {bus1.in_a_re, bus1.in_a_im}, {bus1.in_b_re, bus1.in_b_im});
    end

    task automatic cmp(input int i, input string tag, input logic v,
                       input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi);
        if (armed[i]) begin
            chk({tag, "_model_vld"}, 16'(v), 16'(ev[i]));
            if (known[i]) begin
                chk({tag, "_model_a_re"}, ar, ea[i][31:16]);
                chk({tag, "_model_a_im"}, ai, ea[i][15:0]);
                chk({tag, "_model_b_re"}, br, eb[i][31:16]);
                chk({tag, "_model_b_im"}, bi, eb[i][15:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        cmp(0, "d2", bus2.out_valid, bus2.out_a_re, bus2.out_a_im, bus2.out_b_re, bus2.out_b_im);
        cmp(1, "d1", bus1.out_valid, bus1.out_a_re, bus1.out_a_im, bus1.out_b_re, bus1.out_b_im);
    end

    // Hand-computed output re/im for the k=0..5 stream at DELAY=2.
    int ta_re [4];
    int tb_re [4];
    int ta_im [4];
    int tb_im [4];
    logic [15:0] lp;
    logic [15:0] ln;

    task automatic drv2(input bit v, input int k, input bit r);
        bus2.in_valid = v;
        bus2.in_a_re  = 16'(k);
        bus2.in_a_im  = 16'(-k);
        bus2.in_b_re  = 16'(100 + k);
        bus2.in_b_im  = 16'(-(100 + k));
        rst2 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input bit v, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi, input bit r);
        bus1.in_valid = v;
        bus1.in_a_re  = ar;
        bus1.in_a_im  = ai;
        bus1.in_b_re  = br;
        bus1.in_b_im  = bi;
        rst1 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic lit2(input string nm, input int j);
        chk({nm, "_vld"},  16'(bus2.out_valid), 16'd1);
        chk({nm, "_a_re"}, bus2.out_a_re, 16'(ta_re[j]));
        chk({nm, "_a_im"}, bus2.out_a_im, 16'(ta_im[j]));
        chk({nm, "_b_re"}, bus2.out_b_re, 16'(tb_re[j]));
        chk({nm, "_b_im"}, bus2.out_b_im, 16'(tb_im[j]));
    endtask

    task automatic seq2(input string nm);
        for (int k = 0; k < 6; k++) begin
            drv2(1, k, 0);
            if (k < 2) chk({nm, "_unprimed_vld"}, 16'(bus2.out_valid), 16'd0);
            else       lit2(nm, k - 2);
        end
    endtask

    task automatic drv1_ext(input int k);
        if (k % 2 == 0) drv1(1, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 0);
        else            drv1(1, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
    endtask

    initial begin
`ifdef COMMUTATOR_SCALE_EN
        ta_re = '{0, 1, 50, 51};    tb_re = '{1, 2, 51, 52};
        ta_im = '{0, 0, -50, -50};  tb_im = '{-1, -1, -51, -51};
        lp = 16'h4000; ln = 16'hC000;
`else
        ta_re = '{0, 1, 100, 101};  tb_re = '{2, 3, 102, 103};
        ta_im = '{0, -1, -100, -101}; tb_im = '{-2, -3, -102, -103};
        lp = 16'h7FFF; ln = 16'h8000;
`endif
        rst1 = 1'b1;
        bus1.in_valid = 0; bus1.in_a_re = 0; bus1.in_a_im = 0; bus1.in_b_re = 0; bus1.in_b_im = 0;

        // Reset state
        drv2(0, 0, 1);
        drv2(0, 0, 1);
        chk("rst_vld", 16'(bus2.out_valid), 16'd0);
        chk("rst_a_re", bus2.out_a_re, 16'd0);
        chk("rst_b_im", bus2.out_b_im, 16'd0);
        chk("rst1_vld", 16'(bus1.out_valid), 16'd0);

        // Back-to-back reorder
        seq2("reorder");

        // Stall after k=2: outputs hold, valid drops for exactly the idle cycles
        drv2(0, 0, 1);
        for (int k = 0; k < 3; k++) drv2(1, k, 0);
        lit2("stall_pre", 0);
        for (int s = 0; s < 3; s++) begin
            drv2(0, 99, 0);
            chk("stall_vld",  16'(bus2.out_valid), 16'd0);
            chk("stall_hold_a", bus2.out_a_re, 16'(ta_re[0]));
            chk("stall_hold_b", bus2.out_b_re, 16'(tb_re[0]));
        end
        for (int k = 3; k < 6; k++) begin
            drv2(1, k, 0);
            lit2("stall_post", k - 2);
        end

        // Reset mid-stream with a simultaneous valid sample
        drv2(0, 0, 1);
        for (int k = 0; k < 4; k++) drv2(1, k, 0);
        drv2(1, 4, 1);
        chk("midrst_vld",  16'(bus2.out_valid), 16'd0);
        chk("midrst_a_re", bus2.out_a_re, 16'd0);
        chk("midrst_a_im", bus2.out_a_im, 16'd0);
        chk("midrst_b_re", bus2.out_b_re, 16'd0);
        chk("midrst_b_im", bus2.out_b_im, 16'd0);
        seq2("restart");

        // Longer stream across several counter wraps with periodic stalls
        for (int k = 6; k < 30; k++) begin
            if (k % 5 == 3) drv2(0, k, 0);
            drv2(1, k, 0);
        end
        drv2(0, 0, 0);

        // DELAY=1 extremes: alternating (a0,a1),(b0,b1)
        drv1(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            drv1_ext(k);
            if (k == 0) begin
                chk("d1_unprimed_vld", 16'(bus1.out_valid), 16'd0);
            end else if (k % 2 == 1) begin
                chk("d1_aa_vld",  16'(bus1.out_valid), 16'd1);
                chk("d1_aa_a_re", bus1.out_a_re, lp);
                chk("d1_aa_a_im", bus1.out_a_im, ln);
                chk("d1_aa_b_re", bus1.out_b_re, ln);
                chk("d1_aa_b_im", bus1.out_b_im, lp);
            end else begin
                chk("d1_bb_vld",  16'(bus1.out_valid), 16'd1);
                chk("d1_bb_a_re", bus1.out_a_re, ln);
                chk("d1_bb_a_im", bus1.out_a_im, ln);
                chk("d1_bb_b_re", bus1.out_b_re, lp);
                chk("d1_bb_b_im", bus1.out_b_im, lp);
            end
        end
        drv1(0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 0);
        chk("d1_stall_vld",  16'(bus1.out_valid), 16'd0);
        chk("d1_stall_hold", bus1.out_a_re, ln);

        // DELAY=1 varied data, with a stall and a reset colliding with valid
        for (int k = 7; k < 15; k++) begin
            if (k == 10) drv1(0, 0, 0, 0, 0, 0);
            drv1(1, 16'(k * 1237), 16'(-k * 311), 16'(k * 4099 + 7), 16'(k * 29 - 500), 0);
        end
        drv1(1, 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 1);
        chk("d1_midrst_vld", 16'(bus1.out_valid), 16'd0);
        chk("d1_midrst_b_re", bus1.out_b_re, 16'd0);
        for (int k = 0; k < 5; k++) drv1(1, 16'(k + 3), 16'(k - 9), 16'(k * 77), 16'(-k), 0);
        drv1(0, 0, 0, 0, 0, 0);
        drv2(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/r2mdc_commutator.md
R2MDC_COMMUTATOR -- requirements
Module: r2mdc_commutator

Interface
REQ-001 Parameter DELAY, default 4; delay-line depth in samples; SHALL be a power of two, 1 or more.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  input sample pair valid this cycle.
REQ-005 in_a_re, in_a_im  input  16 each  upper path from butterfly Y0; signed Q7.8.
REQ-006 in_b_re, in_b_im  input  16 each  lower path from butterfly Y1; signed Q7.8.
REQ-007 out_valid  output  1  output pair valid.
REQ-008 out_a_re, out_a_im  output  16 each  next-stage butterfly A input; signed Q7.8.
REQ-009 out_b_re, out_b_im  output  16 each  next-stage butterfly B input; signed Q7.8.

Function
REQ-010 Lower delay line L SHALL be DELAY deep and take in_b; it advances only on cycles where in_valid=1.
REQ-011 Upper delay line U SHALL be DELAY deep and take the switch upper output; it advances only when in_valid=1.
REQ-012 Counter cnt SHALL count accepted samples modulo 2*DELAY; sel = (cnt div DELAY) mod 2.
REQ-013 sel=0 (straight): sw_up = in_a and sw_lo = L output.
REQ-014 sel=1 (cross): sw_up = L output and sw_lo = in_a.
REQ-015 out_a SHALL be the U output and out_b SHALL be sw_lo, each with re and im moving together.
REQ-016 Outputs SHALL be registered, with one cycle of latency from the accepting in_valid cycle.
REQ-017 Priming: a primed flag SHALL set when the DELAY-th accepted sample (index DELAY-1) is taken.
REQ-018 out_valid SHALL equal in_valid AND primed from the prior cycle; the first valid output is produced by sample index DELAY.
REQ-019 Once primed, every accepted input SHALL yield exactly one output pair; no bubbles are inserted.
REQ-020 Stall: when in_valid=0, cnt, L, U and primed SHALL hold, out_valid SHALL go to 0 next cycle, and output data SHALL hold its last value.
REQ-021 cnt SHALL wrap from 2*DELAY-1 to 0 without a gap; sel toggles every DELAY accepted samples.
REQ-022 Operation is continuous-stream; frame tails drain only by further valid input, and no flush port exists.
REQ-023 DELAY=1 SHALL be supported: cnt is 1 bit and sel = cnt.

Reset
REQ-024 rst=1 SHALL clear cnt, primed and out_valid to 0 and all out_* data to 0 on the next edge.
REQ-025 L and U contents SHALL NOT require reset; by construction, unprimed contents never reach a valid output.
REQ-026 Reset mid-stream SHALL discard in-flight samples; after reset the block re-primes from cnt=0.
REQ-027 rst SHALL take priority over a simultaneous in_valid, and that sample is dropped.

Configuration
REQ-028 Macro COMMUTATOR_SCALE_EN.
REQ-029 When COMMUTATOR_SCALE_EN is defined, each output component SHALL be (x+1)>>>1, computed at 17 bits and truncated to 16 bits (round half up, divide by 2).
REQ-030 When COMMUTATOR_SCALE_EN is undefined, outputs SHALL be bit-exact pass-through of the reordered samples.
REQ-031 Scaling SHALL add no latency.

Verification (DELAY=2; a_k.re=k, b_k.re=100+k, im=-re)
REQ-032 Reorder: 6 back-to-back valid pairs k=0..5 -> no out_valid for the first 2 accepts, then outputs (a0,a2),(a1,a3),(b0,b2),(b1,b3) with re values (0,2),(1,3),(100,102),(101,103).
REQ-033 Stall: deassert in_valid for 3 cycles after k=2 -> out_valid low for exactly those cycles, data held, and the subsequent sequence is identical to REQ-032.
REQ-034 Reset mid-stream: rst for one cycle after k=3 together with in_valid=1 -> out_valid=0 and all outputs 0; that sample is dropped, and restarting at k=0 gives the REQ-032 sequence.
REQ-035 Scale build: same stimulus with COMMUTATOR_SCALE_EN -> re outputs (0,1),(1,2),(50,51),(51,52), and im -2 -> -1, -1 -> 0, -103 -> -51.
REQ-036 Wrap/extremes with DELAY=1 and inputs 0x7FFF/0x8000 -> outputs alternate (a0,a1),(b0,b1) every cycle with exact values, and the scaled build gives 0x4000/0xC000.
